md_sched: RTL and testbench

Multiply/divide scheduler for the execute stage of the pipelined CPU. It accepts one HI/LO-class instruction at a time from the E stage alongside the ALU. It sequences a fixed-latency multiply or divide, and owns the HI and LO architectural registers. It raises `busy` so the hazard unit can stall later HI/LO instructions in D. It also supports flush, so an in-flight operation can be killed when a victim instruction is cancelled.

---
 rtl/md_sched_pkg.sv | 25 ++
 rtl/md_sched_calc.sv | 66 ++++++
 rtl/md_sched.sv | 134 +++++++++++++
 tb/tb_md_sched.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/md_sched_pkg.sv
// Shared definitions for the multiply/divide scheduler: HI/LO-class opcodes,
// default latencies and the scheduler state type.
package md_sched_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_MFHI  = 4'd7,
        MD_MFLO  = 4'd8
    } md_op_t;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_t;

endpackage

// File: rtl/md_sched_calc.sv
// Combinational arithmetic core: 64-bit product and quotient/remainder for the
// four HI/LO arithmetic ops, plus a divide-by-zero flag.
module md_calc
    import md_sched_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div_zero
);

    logic        signed_op;
    logic        is_sdiv;
    logic        is_div;
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] prod;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] uq;
    logic [31:0] ur;
    logic [31:0] quot;
    logic [31:0] rem;

    // Signed divide works on magnitudes so that -2^31 / -1 wraps cleanly.
    always_comb begin
        signed_op = (op == MD_MULT) || (op == MD_DIV);
        is_sdiv   = (op == MD_DIV);
        is_div    = (op == MD_DIV) || (op == MD_DIVU);

        ext_a = signed_op ? {{32{a[31]}}, a} : {32'b0, a};
        ext_b = signed_op ? {{32{b[31]}}, b} : {32'b0, b};
        prod  = ext_a * ext_b;

        div_zero = is_div && (b == 32'd0);

        mag_a = (is_sdiv && a[31]) ? -a : a;
        mag_b = (is_sdiv && b[31]) ? -b : b;
        if (b == 32'd0) begin
            uq = 32'd0;
            ur = 32'd0;
        end else begin
            uq = mag_a / mag_b;
            ur = mag_a % mag_b;
        end
        quot = (is_sdiv && (a[31] ^ b[31])) ? -uq : uq;
        rem  = (is_sdiv && a[31]) ? -ur : ur;

        res_hi = 32'd0;
        res_lo = 32'd0;
        case (op)
            MD_MULT, MD_MULTU: begin
                res_hi = prod[63:32];
                res_lo = prod[31:0];
            end
            MD_DIV, MD_DIVU: begin
                res_hi = rem;
                res_lo = quot;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/md_sched.sv
// Multiply/divide scheduler: sequences fixed-latency MULT/DIV ops, owns HI/LO,
// and reports busy to the hazard unit. Supports flush of the in-flight op.
module md_sched
    import md_sched_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [3:0]  md_op,
    input  logic [31:0] inA,
    input  logic [31:0] inB,
    input  logic        flush,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] md_out
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

    md_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      pend_hi_q, pend_hi_d;
    logic [31:0]      pend_lo_q, pend_lo_d;
    logic             pend_dz_q, pend_dz_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;

    logic [31:0]      calc_hi;
    logic [31:0]      calc_lo;
    logic             calc_dz;

    md_calc u_calc (
        .op       (md_op),
        .a        (inA),
        .b        (inB),
        .res_hi   (calc_hi),
        .res_lo   (calc_lo),
        .div_zero (calc_dz)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= CNT_ZERO;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            pend_dz_q <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_dz_q <= pend_dz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    // Result is captured at start; the countdown only delays its commit.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_dz_d = pend_dz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        case (state_q)
            ST_IDLE: begin
                if (start && !flush) begin
                    case (md_op)
                        MD_MULT, MD_MULTU: begin
                            pend_hi_d = calc_hi;
                            pend_lo_d = calc_lo;
                            pend_dz_d = 1'b0;
                            cnt_d     = MULT_LOAD;
                            state_d   = ST_RUN;
                        end
                        MD_DIV, MD_DIVU: begin
                            pend_hi_d = calc_hi;
                            pend_lo_d = calc_lo;
                            pend_dz_d = calc_dz;
                            cnt_d     = DIV_LOAD;
                            state_d   = ST_RUN;
                        end
                        MD_MTHI: hi_d = inA;
                        MD_MTLO: lo_d = inA;
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                if (flush) begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == CNT_ONE) begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                    if (!pend_dz_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    always_comb begin
        busy   = (state_q == ST_RUN);
        hi     = hi_q;
        lo     = lo_q;
        md_out = (md_op == MD_MFHI) ? hi_q : lo_q;
    end

endmodule

// File: tb/tb_md_sched.sv
// Self-checking bench for md_sched: directed cases plus random ops compared
// against an arithmetic reference model of HI/LO.
module tb_md_sched;
    import md_sched_pkg::*;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [3:0]  md_op;
    logic [31:0] inA;
    logic [31:0] inB;
    logic        flush;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] md_out;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] m_hi     = 32'd0;
    logic [31:0] m_lo     = 32'd0;

    always #5 clk = ~clk;

    md_sched #(
        .MULT_CYCLES (MULT_N),
        .DIV_CYCLES  (DIV_N)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .md_op   (md_op),
        .inA     (inA),
        .inB     (inB),
        .flush   (flush),
        .busy    (busy),
        .hi      (hi),
        .lo      (lo),
        .md_out  (md_out)
    );

    // The hazard unit must never present an unflushed start while busy.
    always @(negedge clk) begin
        if (reset_n && start && !flush) begin
            n_assert++;
            assert (busy === 1'b0) else begin
                n_fail++;
                $error("[TB] FAIL protocol: start while busy, observed busy=%0b expected 0", busy);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] rh, output logic [31:0] rl, output bit dz);
        longint      sp;
        longint      sq;
        longint      sr;
        logic [63:0] up;
        rh = 32'd0;
        rl = 32'd0;
        dz = 1'b0;
        case (op)
            MD_MULT: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                rh = sp[63:32];
                rl = sp[31:0];
            end
            MD_MULTU: begin
                up = {32'b0, a} * {32'b0, b};
                rh = up[63:32];
                rl = up[31:0];
            end
            MD_DIV: begin
                if (b == 32'd0) dz = 1'b1;
                else begin
                    sq = longint'($signed(a)) / longint'($signed(b));
                    sr = longint'($signed(a)) % longint'($signed(b));
                    rl = sq[31:0];
                    rh = sr[31:0];
                end
            end
            MD_DIVU: begin
                if (b == 32'd0) dz = 1'b1;
                else begin
                    rl = a / b;
                    rh = a % b;
                end
            end
            default: ;
        endcase
    endfunction

    task automatic check_md_out();
        md_op = MD_MFHI;
        #1;
        checkOutput("md_out_mfhi", md_out, m_hi);
        md_op = MD_MFLO;
        #1;
        checkOutput("md_out_mflo", md_out, m_lo);
        md_op = MD_NONE;
    endtask

    // flush_at = k asserts flush (with a stray MULT start) in busy cycle k; 0 = no flush.
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input int flush_at);
        logic [31:0] e_hi;
        logic [31:0] e_lo;
        bit          dz;
        bit          killed;
        int          n;
        model(op, a, b, e_hi, e_lo, dz);
        md_op = op;
        inA   = a;
        inB   = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        md_op = MD_NONE;
        inA   = $urandom;
        inB   = $urandom;
        if (op == MD_MULT || op == MD_MULTU || op == MD_DIV || op == MD_DIVU) begin
            n      = (op == MD_MULT || op == MD_MULTU) ? MULT_N : DIV_N;
            killed = 1'b0;
            for (int k = 1; k <= n && !killed; k++) begin
                checkOutput("busy_run", 32'(busy), 32'd1);
                checkOutput("hi_hold", hi, m_hi);
                if (k == flush_at) begin
                    flush  = 1'b1;
                    start  = 1'b1;
                    md_op  = MD_MULT;
                    killed = 1'b1;
                end
                tick();
                flush = 1'b0;
                start = 1'b0;
                md_op = MD_NONE;
            end
            checkOutput("busy_done", 32'(busy), 32'd0);
            if (!killed && !dz) begin
                m_hi = e_hi;
                m_lo = e_lo;
            end
            checkOutput("hi_result", hi, m_hi);
            checkOutput("lo_result", lo, m_lo);
            if (killed) begin
                tick();
                checkOutput("busy_after_flush", 32'(busy), 32'd0);
            end
        end else begin
            if (op == MD_MTHI) m_hi = a;
            if (op == MD_MTLO) m_lo = a;
            checkOutput("busy_mt", 32'(busy), 32'd0);
            checkOutput("hi_mt", hi, m_hi);
            checkOutput("lo_mt", lo, m_lo);
        end
    endtask

    initial begin
        logic [3:0] ops [6];
        logic [3:0] r_op;
        logic [31:0] r_a;
        logic [31:0] r_b;
        int          r_flush;
        ops[0] = MD_MULT;  ops[1] = MD_MULTU; ops[2] = MD_DIV;
        ops[3] = MD_DIVU;  ops[4] = MD_MTHI;  ops[5] = MD_MTLO;

        reset_n = 1'b0;
        start   = 1'b0;
        flush   = 1'b0;
        md_op   = MD_NONE;
        inA     = 32'd0;
        inB     = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_hi", hi, 32'd0);
        checkOutput("reset_lo", lo, 32'd0);
        reset_n = 1'b1;
        tick();

        $display("[TB] directed arithmetic");
        applyStimulus(MD_MULT, 32'hFFFF_FFFD, 32'd5, 0);
        checkOutput("mult_hi_const", hi, 32'hFFFF_FFFF);
        checkOutput("mult_lo_const", lo, 32'hFFFF_FFF1);
        applyStimulus(MD_MULTU, 32'hFFFF_FFFF, 32'd2, 0);
        checkOutput("multu_hi_const", hi, 32'h0000_0001);
        checkOutput("multu_lo_const", lo, 32'hFFFF_FFFE);
        applyStimulus(MD_DIV, 32'hFFFF_FFF9, 32'd2, 0);
        checkOutput("div_lo_const", lo, 32'hFFFF_FFFD);
        checkOutput("div_hi_const", hi, 32'hFFFF_FFFF);
        applyStimulus(MD_DIVU, 32'd7, 32'd2, 0);
        checkOutput("divu_lo_const", lo, 32'd3);
        checkOutput("divu_hi_const", hi, 32'd1);

        $display("[TB] divide by zero");
        applyStimulus(MD_MTHI, 32'h11, 32'd0, 0);
        applyStimulus(MD_MTLO, 32'h22, 32'd0, 0);
        applyStimulus(MD_DIV, 32'h1234, 32'd0, 0);
        checkOutput("dz_hi_const", hi, 32'h11);
        checkOutput("dz_lo_const", lo, 32'h22);
        check_md_out();

        $display("[TB] flush cases");
        applyStimulus(MD_MULT, 32'd3, 32'd4, 3);
        checkOutput("flush_hi_const", hi, 32'h11);
        checkOutput("flush_lo_const", lo, 32'h22);
        applyStimulus(MD_DIVU, 32'd100, 32'd7, DIV_N);
        checkOutput("flush_commit_lo", lo, 32'h22);
        start = 1'b1;
        flush = 1'b1;
        md_op = MD_MTHI;
        inA   = 32'hDEAD_BEEF;
        tick();
        start = 1'b0;
        flush = 1'b0;
        md_op = MD_NONE;
        checkOutput("flush_mthi_hi", hi, 32'h11);
        checkOutput("flush_mthi_busy", 32'(busy), 32'd0);

        $display("[TB] signed overflow boundary");
        applyStimulus(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        checkOutput("div_ovf_lo", lo, 32'h8000_0000);
        checkOutput("div_ovf_hi", hi, 32'd0);

        $display("[TB] async reset mid-divide");
        md_op = MD_DIV;
        inA   = 32'd100;
        inB   = 32'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        md_op = MD_NONE;
        repeat (3) tick();
        reset_n = 1'b0;
        #1;
        m_hi = 32'd0;
        m_lo = 32'd0;
        checkOutput("areset_busy", 32'(busy), 32'd0);
        checkOutput("areset_hi", hi, 32'd0);
        checkOutput("areset_lo", lo, 32'd0);
        #2;
        reset_n = 1'b1;
        tick();
        checkOutput("post_reset_busy", 32'(busy), 32'd0);
        applyStimulus(MD_DIV, 32'hFFFF_FF9C, 32'd7, 0);
        checkOutput("post_reset_div_lo", lo, 32'hFFFF_FFF2);
        checkOutput("post_reset_div_hi", hi, 32'hFFFF_FFFE);

        $display("[TB] random ops");
        for (int i = 0; i < 40; i++) begin
            r_op    = ops[$urandom_range(5)];
            r_a     = ($urandom_range(3) == 0) ? 32'($urandom_range(255)) : $urandom;
            r_b     = ($urandom_range(7) == 0) ? 32'd0 :
                      (($urandom_range(2) == 0) ? 32'($urandom_range(15)) : $urandom);
            r_flush = ($urandom_range(5) == 0) ? int'($urandom_range(1, MULT_N)) : 0;
            applyStimulus(r_op, r_a, r_b, r_flush);
            check_md_out();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
